// File: rtl/mem_pkg.sv
// Shared types and decode helpers for the MEM-stage load/store unit.
package mem_pkg;

    typedef enum logic [3:0] {
        LB   = 4'd0,
        LH   = 4'd1,
        LW   = 4'd2,
        LBU  = 4'd3,
        LHU  = 4'd4,
        SB   = 4'd5,
        SH   = 4'd6,
        SW   = 4'd7,
        NONE = 4'd8
    } rw_code_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Codes with [3]=1 that the decoder never emits fall back to LW.
    function automatic rw_code_t decode_rw(input logic [3:0] rw);
        rw_code_t c;
        case (rw)
            4'b1000: c = LB;
            4'b1001: c = LH;
            4'b1010: c = LW;
            4'b1100: c = LBU;
            4'b1101: c = LHU;
            4'b1011: c = SB;
            4'b1110: c = SH;
            4'b1111: c = SW;
            default: c = rw[3] ? LW : NONE;
        endcase
        return c;
    endfunction

    function automatic logic is_store(input rw_code_t c);
        return (c == SB) || (c == SH) || (c == SW);
    endfunction

    function automatic logic [1:0] size_of(input rw_code_t c);
        logic [1:0] s;
        case (c)
            LB, LBU, SB: s = SZ_B;
            LH, LHU, SH: s = SZ_H;
            default:     s = SZ_W;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Selects the addressed byte/halfword of a read word and sign- or zero-extends it.
module load_formatter
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rdata,
    input  logic [1:0]      i_off,
    input  logic [3:0]      i_code,
    output logic [XLEN-1:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection followed by extension according to the load code.
    always_comb begin
        w_byte      = 8'h00;
        w_half      = 16'h0000;
        o_load_data = {XLEN{1'b0}};
        case (i_off)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
        if (i_off[1]) begin
            w_half = i_rdata[31:16];
        end else begin
            w_half = i_rdata[15:0];
        end
        case (rw_code_t'(i_code))
            LB:      o_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            LBU:     o_load_data = {{(XLEN-8){1'b0}}, w_byte};
            LH:      o_load_data = {{(XLEN-16){w_half[15]}}, w_half};
            LHU:     o_load_data = {{(XLEN-16){1'b0}}, w_half};
            LW:      o_load_data = i_rdata;
            default: o_load_data = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: runs one req/gnt/rvalid data-memory transaction per accepted op
// and stalls the pipeline until it completes.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      read_write,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    input  logic [4:0]      rd,
    output logic            out_valid,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] load_data,
    output logic            misaligned,
    output logic            bus_error,
    output logic            stall,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata
);

    localparam int CW = $clog2(TIMEOUT);

    state_t          r_state;
    state_t          w_next;
    rw_code_t        r_code;
    rw_code_t        w_code;
    logic [1:0]      r_off;
    logic [CW-1:0]   r_tmo;
    logic [1:0]      w_size;
    logic            w_mis;
    logic            w_accept;
    logic            w_tmo_hit;
    logic            w_tmo_fault;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_fmt;

    logic            r_out_valid;
    logic [4:0]      r_out_rd;
    logic [XLEN-1:0] r_load_data;
    logic            r_misaligned;
    logic            r_bus_error;
    logic            r_dmem_req;
    logic            r_dmem_we;
    logic [3:0]      r_dmem_be;
    logic [XLEN-1:0] r_dmem_addr;
    logic [XLEN-1:0] r_dmem_wdata;

    assign w_code    = decode_rw(read_write);
    assign w_size    = size_of(w_code);
    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_tmo_hit = (r_tmo == CW'(TIMEOUT - 1));

    assign in_ready   = (r_state == IDLE) && !rst;
    assign stall      = (r_state != IDLE);
    assign out_valid  = r_out_valid;
    assign out_rd     = r_out_rd;
    assign load_data  = r_load_data;
    assign misaligned = r_misaligned;
    assign bus_error  = r_bus_error;
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_be    = r_dmem_be;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;

    load_formatter #(.XLEN(XLEN)) u_fmt (
        .i_rdata     (dmem_rdata),
        .i_off       (r_off),
        .i_code      (r_code),
        .o_load_data (w_fmt)
    );

    // Byte enables, store-lane replication and alignment check for the incoming op.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = store_data;
        w_mis   = 1'b0;
        case (w_size)
            SZ_B: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {(XLEN/8){store_data[7:0]}};
                w_mis   = 1'b0;
            end
            SZ_H: begin
                w_be    = 4'b0011 << addr[1:0];
                w_wdata = {(XLEN/16){store_data[15:0]}};
                w_mis   = addr[0];
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = store_data;
                w_mis   = (addr[1:0] != 2'b00);
            end
        endcase
        if (w_code == NONE) begin
            w_mis = 1'b0;
        end else begin
            w_mis = w_mis;
        end
    end

    // Next-state logic; a timeout in REQ or WAIT_R completes the op with a fault.
    always_comb begin
        w_next      = r_state;
        w_tmo_fault = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if ((w_code == NONE) || w_mis) begin
                        w_next = RESP;
                    end else begin
                        w_next = REQ;
                    end
                end else begin
                    w_next = IDLE;
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    w_next = is_store(r_code) ? RESP : WAIT_R;
                end else if (w_tmo_hit) begin
                    w_next      = RESP;
                    w_tmo_fault = 1'b1;
                end else begin
                    w_next = REQ;
                end
            end
            WAIT_R: begin
                if (dmem_rvalid) begin
                    w_next = RESP;
                end else if (w_tmo_hit) begin
                    w_next      = RESP;
                    w_tmo_fault = 1'b1;
                end else begin
                    w_next = WAIT_R;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State, timeout counter, bus request registers and completion outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_code       <= NONE;
            r_off        <= 2'b00;
            r_tmo        <= {CW{1'b0}};
            r_out_valid  <= 1'b0;
            r_out_rd     <= 5'd0;
            r_load_data  <= {XLEN{1'b0}};
            r_misaligned <= 1'b0;
            r_bus_error  <= 1'b0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_be    <= 4'b0000;
            r_dmem_addr  <= {XLEN{1'b0}};
            r_dmem_wdata <= {XLEN{1'b0}};
        end else begin
            r_state      <= w_next;
            r_out_valid  <= (w_next == RESP);
            r_misaligned <= w_accept && w_mis;
            r_bus_error  <= w_tmo_fault;
            if (w_next != r_state) begin
                r_tmo <= {CW{1'b0}};
            end else if ((r_state == REQ) || (r_state == WAIT_R)) begin
                r_tmo <= r_tmo + CW'(1);
            end
            if (w_accept) begin
                r_code   <= w_code;
                r_off    <= addr[1:0];
                r_out_rd <= rd;
            end
            if (w_accept && (w_next == REQ)) begin
                r_dmem_req   <= 1'b1;
                r_dmem_we    <= is_store(w_code);
                r_dmem_be    <= w_be;
                r_dmem_addr  <= {addr[XLEN-1:2], 2'b00};
                r_dmem_wdata <= is_store(w_code) ? w_wdata : {XLEN{1'b0}};
            end else if ((r_state == REQ) && (dmem_gnt || w_tmo_hit)) begin
                r_dmem_req <= 1'b0;
            end
            // Only a genuine read-data beat produces non-zero load data.
            if (w_next == RESP) begin
                r_load_data <= ((r_state == WAIT_R) && dmem_rvalid) ? w_fmt : {XLEN{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Table-driven bench for mem_access_unit with a completion scoreboard and a reactive bus model.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  read_write;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        out_valid;
    logic [4:0]  out_rd;
    logic [31:0] load_data;
    logic        misaligned;
    logic        bus_error;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    mem_access_unit #(.XLEN(32), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .read_write  (read_write),
        .addr        (addr),
        .store_data  (store_data),
        .rd          (rd),
        .out_valid   (out_valid),
        .out_rd      (out_rd),
        .load_data   (load_data),
        .misaligned  (misaligned),
        .bus_error   (bus_error),
        .stall       (stall),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_be     (dmem_be),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata)
    );

    typedef struct {
        string       name;
        logic [3:0]  rw;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  rd;
        int          gnt_dly;   // -1: never granted
        int          rv_dly;    // -1: never returns data
        logic [31:0] rdata;
        logic        exp_req;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_daddr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_ld;
        logic        exp_mis;
        logic        exp_berr;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] ld;
        logic        mis;
        logic        berr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_done = 0;
    int done_cyc = 0;
    int stall_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    // Scoreboard: every completion pulse is matched against the oldest pushed expectation.
    always @(negedge clk) begin
        if (stall === 1'b1) stall_cnt++;
        if (out_valid === 1'b1) begin
            done_cyc = cyc;
            n_done++;
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_rd", 32'(out_rd), 32'(mon_e.rd));
                check("load_data", load_data, mon_e.ld);
                check("misaligned", 32'(misaligned), 32'(mon_e.mis));
                check("bus_error", 32'(bus_error), 32'(mon_e.berr));
            end
        end
    end

    function automatic vec_t mk(string nm, logic [3:0] rw, logic [31:0] a, logic [31:0] sd,
                                logic [4:0] r, int g, int rv, logic [31:0] rdt, logic rq,
                                logic we, logic [3:0] be, logic [31:0] da, logic [31:0] wd,
                                logic [31:0] ld, logic mis, logic berr, int lat);
        vec_t v;
        v.name = nm; v.rw = rw; v.addr = a; v.sdata = sd; v.rd = r;
        v.gnt_dly = g; v.rv_dly = rv; v.rdata = rdt; v.exp_req = rq; v.exp_we = we;
        v.exp_be = be; v.exp_daddr = da; v.exp_wdata = wd; v.exp_ld = ld;
        v.exp_mis = mis; v.exp_berr = berr; v.exp_lat = lat;
        return v;
    endfunction

    task automatic run_op(input vec_t v);
        int   acc;
        int   base;
        int   req_cycles;
        int   exp_rc;
        logic stable;
        exp_t e;
        @(posedge clk); #1;
        check({v.name, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; read_write = v.rw; addr = v.addr; store_data = v.sdata; rd = v.rd;
        e.rd = v.rd; e.ld = v.exp_ld; e.mis = v.exp_mis; e.berr = v.exp_berr;
        exp_q.push_back(e);
        acc = cyc; base = n_done; stall_cnt = 0;
        @(posedge clk); #1;
        in_valid = 1'b0; read_write = 4'b0000; addr = $urandom; store_data = $urandom; rd = 5'd0;
        if (!v.exp_req) begin
            check({v.name, "_no_req"}, 32'(dmem_req), 32'd0);
        end else begin
            stable = 1'b1;
            req_cycles = 0;
            for (int k = 0; k < 64; k++) begin
                if (dmem_req !== 1'b1 || dmem_we !== v.exp_we || dmem_be !== v.exp_be ||
                    dmem_addr !== v.exp_daddr || (v.exp_we && dmem_wdata !== v.exp_wdata))
                    stable = 1'b0;
                req_cycles++;
                if (k == v.gnt_dly) begin
                    dmem_gnt = 1'b1;
                    if (!v.exp_we) begin
                        dmem_rvalid = 1'b1;
                        dmem_rdata  = 32'h5A5A5A5A;
                    end
                    @(posedge clk); #1;
                    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
                    break;
                end
                @(posedge clk); #1;
                if (dmem_req !== 1'b1) break;
            end
            exp_rc = (v.gnt_dly < 0) ? 16 : v.gnt_dly + 1;
            check({v.name, "_req_stable"}, 32'(stable), 32'd1);
            check({v.name, "_req_cycles"}, 32'(req_cycles), 32'(exp_rc));
            if (!v.exp_we && v.gnt_dly >= 0 && v.rv_dly >= 0) begin
                for (int k = 0; k < v.rv_dly; k++) begin
                    @(posedge clk); #1;
                end
                dmem_rvalid = 1'b1; dmem_rdata = v.rdata;
                @(posedge clk); #1;
                dmem_rvalid = 1'b0; dmem_rdata = $urandom;
            end
        end
        for (int k = 0; k < 64 && n_done == base; k++) @(posedge clk);
        if (n_done == base) begin
            check({v.name, "_completion_timeout"}, 32'd0, 32'd1);
        end else begin
            check({v.name, "_latency"}, 32'(done_cyc - acc), 32'(v.exp_lat));
        end
        @(posedge clk); #1;
        check({v.name, "_stall_cycles"}, 32'(stall_cnt), 32'(v.exp_lat));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   base;
        int   acc;
        exp_t e;
        rst = 1'b1; in_valid = 1'b0; read_write = 4'b0000; addr = 32'd0; store_data = 32'd0;
        rd = 5'd0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;

        //       name        rw       addr         sdata         rd     g   rv  rdata         rq    we    be       daddr        wdata         ld            mis   berr  lat
        vecs.push_back(mk("lw",      4'b1010, 32'h00000100, 32'h00000000, 5'd1,  0,  0, 32'hDEADBEEF, 1'b1, 1'b0, 4'b1111, 32'h00000100, 32'h00000000, 32'hDEADBEEF, 1'b0, 1'b0, 3));
        vecs.push_back(mk("sb",      4'b1011, 32'h00000203, 32'h000000A5, 5'd2,  2, -1, 32'h00000000, 1'b1, 1'b1, 4'b1000, 32'h00000200, 32'hA5A5A5A5, 32'h00000000, 1'b0, 1'b0, 4));
        vecs.push_back(mk("lb",      4'b1000, 32'h00000001, 32'h00000000, 5'd3,  0,  0, 32'h0000F000, 1'b1, 1'b0, 4'b0010, 32'h00000000, 32'h00000000, 32'hFFFFFFF0, 1'b0, 1'b0, 3));
        vecs.push_back(mk("lbu",     4'b1100, 32'h00000001, 32'h00000000, 5'd4,  0,  0, 32'h0000F000, 1'b1, 1'b0, 4'b0010, 32'h00000000, 32'h00000000, 32'h000000F0, 1'b0, 1'b0, 3));
        vecs.push_back(mk("lhu",     4'b1101, 32'h00000002, 32'h00000000, 5'd5,  0,  0, 32'h80010000, 1'b1, 1'b0, 4'b1100, 32'h00000000, 32'h00000000, 32'h00008001, 1'b0, 1'b0, 3));
        vecs.push_back(mk("lh_mis",  4'b1001, 32'h00000003, 32'h00000000, 5'd6,  0,  0, 32'h00000000, 1'b0, 1'b0, 4'b0000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1));
        vecs.push_back(mk("sw_mis",  4'b1111, 32'h00000006, 32'h12345678, 5'd7,  0,  0, 32'h00000000, 1'b0, 1'b0, 4'b0000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1));
        vecs.push_back(mk("addi",    4'b0000, 32'h00000044, 32'h00000000, 5'd8,  0,  0, 32'h00000000, 1'b0, 1'b0, 4'b0000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1));
        vecs.push_back(mk("sh",      4'b1110, 32'h00000102, 32'h1234ABCD, 5'd9,  0, -1, 32'h00000000, 1'b1, 1'b1, 4'b1100, 32'h00000100, 32'hABCDABCD, 32'h00000000, 1'b0, 1'b0, 2));
        vecs.push_back(mk("lh_slow", 4'b1001, 32'h00000002, 32'h00000000, 5'd10, 1,  2, 32'h80017FFF, 1'b1, 1'b0, 4'b1100, 32'h00000000, 32'h00000000, 32'hFFFF8001, 1'b0, 1'b0, 6));
        vecs.push_back(mk("sw",      4'b1111, 32'h00000008, 32'h12345678, 5'd11, 0, -1, 32'h00000000, 1'b1, 1'b1, 4'b1111, 32'h00000008, 32'h12345678, 32'h00000000, 1'b0, 1'b0, 2));
        vecs.push_back(mk("lb_b3",   4'b1000, 32'h00000003, 32'h00000000, 5'd12, 0,  0, 32'h7F000000, 1'b1, 1'b0, 4'b1000, 32'h00000000, 32'h00000000, 32'h0000007F, 1'b0, 1'b0, 3));
        vecs.push_back(mk("tmo_gnt", 4'b1010, 32'h00000300, 32'h00000000, 5'd13, -1, -1, 32'h00000000, 1'b1, 1'b0, 4'b1111, 32'h00000300, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 17));
        vecs.push_back(mk("tmo_rv",  4'b1010, 32'h00000304, 32'h00000000, 5'd14, 0, -1, 32'h00000000, 1'b1, 1'b0, 4'b1111, 32'h00000304, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 18));
        vecs.push_back(mk("lhu_lo",  4'b1101, 32'h00000000, 32'h00000000, 5'd15, 0,  0, 32'h1234FFFE, 1'b1, 1'b0, 4'b0011, 32'h00000000, 32'h00000000, 32'h0000FFFE, 1'b0, 1'b0, 3));
        vecs.push_back(mk("lh_lo",   4'b1001, 32'h00000010, 32'h00000000, 5'd16, 0,  0, 32'h0000FFFE, 1'b1, 1'b0, 4'b0011, 32'h00000010, 32'h00000000, 32'hFFFFFFFE, 1'b0, 1'b0, 3));

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_req_we_be", 32'({dmem_req, dmem_we, dmem_be}), 32'd0);
        check("rst_dmem_addr", dmem_addr, 32'd0);
        check("rst_dmem_wdata", dmem_wdata, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_flags", 32'({out_valid, misaligned, bus_error, stall, out_rd}), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        foreach (vecs[i]) run_op(vecs[i]);

        // Reset while waiting for read data; the late rvalid must be ignored.
        @(posedge clk); #1;
        in_valid = 1'b1; read_write = 4'b1010; addr = 32'h00000400; rd = 5'd20;
        @(posedge clk); #1;
        in_valid = 1'b0; dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        check("rstmid_in_wait_stall", 32'(stall), 32'd1);
        base = n_done;
        rst = 1'b1;
        #1;
        check("rstmid_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
        #1;
        check("rstmid_in_ready", 32'(in_ready), 32'd1);
        check("rstmid_stall", 32'(stall), 32'd0);
        check("rstmid_req_we_be", 32'({dmem_req, dmem_we, dmem_be}), 32'd0);
        check("rstmid_dmem_addr", dmem_addr, 32'd0);
        check("rstmid_outs", 32'({out_valid, misaligned, bus_error, out_rd}), 32'd0);
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        check("rstmid_late_rvalid_load_data", load_data, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rstmid_no_out_valid", 32'(n_done - base), 32'd0);

        // Back-to-back ADDIs: second accept in the cycle right after RESP.
        @(posedge clk); #1;
        in_valid = 1'b1; read_write = 4'b0000; addr = 32'h0; rd = 5'd21;
        e.rd = 5'd21; e.ld = 32'd0; e.mis = 1'b0; e.berr = 1'b0;
        exp_q.push_back(e);
        acc = cyc; base = n_done;
        @(posedge clk); #1;
        rd = 5'd22;
        check("b2b_busy_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("b2b_idle_in_ready", 32'(in_ready), 32'd1);
        e.rd = 5'd22;
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0; rd = 5'd0;
        for (int k = 0; k < 32 && n_done < base + 2; k++) @(posedge clk);
        check("b2b_count", 32'(n_done - base), 32'd2);
        check("b2b_second_latency", 32'(done_cyc - acc), 32'd3);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store unit, directly downstream of the decode control logic.
- Consumes the decoder's 4-bit read_write code, the ALU-computed address and the rs2 store data.
- Runs a req/gnt/rvalid transaction on the data-memory port. Produces byte strobes, aligned write data, and sign/zero-extended load data.
- Stalls the pipeline while a transaction is outstanding.

Parameters:
- XLEN, 32, data/address width
- TIMEOUT, 16, max cycles waiting for dmem_gnt or dmem_rvalid before bus_error (must be >= 2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  MEM request valid
- in_ready  out  1  unit can accept; combinational, high only in IDLE and when rst=0
- read_write  in  4  [3]=mem op; codes: 1000 LB, 1001 LH, 1010 LW, 1100 LBU, 1101 LHU, 1011 SB, 1110 SH, 1111 SW
- addr  in  XLEN  effective byte address
- store_data  in  XLEN  rs2 value
- rd  in  5  destination register, passed through
- out_valid  out  1  one-cycle completion pulse
- out_rd  out  5  rd of the completed op
- load_data  out  XLEN  extended load result; 0 for stores and non-mem ops
- misaligned  out  1  completion carries an alignment fault
- bus_error  out  1  completion carries a timeout fault
- stall  out  1  high when state != IDLE
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_be  out  4  byte enables
- dmem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  XLEN  lane-shifted store data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  XLEN  read word

Behaviour:
- Reset:
  - state=IDLE.
  - out_valid, misaligned, bus_error, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, load_data, out_rd all 0.
  - Timeout counter 0.
  - Reset mid-transaction abandons it with no out_valid; a late dmem_rvalid after reset is ignored.
- FSM states: IDLE, REQ, WAIT_R, RESP.
- IDLE:
  - Accept on in_valid & in_ready; latch read_write, addr, store_data, rd.
  - read_write[3]=0 → RESP; completion has no dmem access and load_data=0.
  - Misaligned → RESP with misaligned=1 and no dmem_req. Halfword (LH/LHU/SH) misaligned when addr[0]=1; word (LW/SW) when addr[1:0]!=0.
  - Otherwise → REQ.
- REQ:
  - dmem_req=1; dmem_we/be/addr/wdata registered and held stable until gnt.
  - gnt & store → RESP.
  - gnt & load → WAIT_R.
  - Timeout counter hits TIMEOUT-1 without gnt → RESP with bus_error=1; dmem_req drops.
- WAIT_R:
  - dmem_req=0.
  - On dmem_rvalid, capture dmem_rdata → RESP.
  - Same timeout rule; the counter is cleared on each state entry.
- RESP: out_valid=1 for exactly one cycle, then → IDLE.
- dmem_rvalid in the same cycle as gnt is not accepted; rvalid is sampled only in WAIT_R.
- Byte enables:
  - SB/LB/LBU: 4'b0001<<addr[1:0].
  - SH/LH/LHU: 4'b0011<<addr[1:0].
  - SW/LW: 4'b1111.
- Store data: SB replicates byte [7:0] to all lanes; SH replicates [15:0] to both halves; SW passes unchanged.
- Load extraction: select the byte/half by addr[1:0]; LB/LH sign-extend; LBU/LHU zero-extend; LW passes unchanged.
- Latency from accept cycle T:
  - Non-mem or misaligned: out_valid at T+1.
  - Store with gnt at first req cycle (T+1): out_valid at T+2.
  - Load with gnt at T+1 and rvalid at T+2: out_valid at T+3.
- Back-to-back: the next accept is possible in the cycle after RESP.
- Illegal 4-bit codes with [3]=1 (none exist from the decoder) are treated as LW.

Decomposition:
- Shared package mem_pkg:
  - rw_code enum: LB, LH, LW, LBU, LHU, SB, SH, SW, NONE.
  - state enum.
  - Size helper functions: is_store, size_of.
- Sub-module load_formatter, purely combinational: rdata, addr[1:0], code → load_data.
- Byte-enable and store-lane logic stays inline.

Test Plan:
- LW addr=0x100, gnt at first req, rvalid next cycle, rdata=0xDEADBEEF → dmem_addr=0x100, be=1111, we=0; out_valid 3 cycles after accept; load_data=0xDEADBEEF; stall high for 3 cycles.
- SB addr=0x203, store_data=0x000000A5, gnt delayed 2 cycles → dmem_addr=0x200, be=1000, wdata=0xA5A5A5A5, we=1; req/be/wdata stable until gnt; out_valid at gnt+1.
- LB addr=0x1, rdata=0x0000F000 → load_data=0xFFFFFFF0. LBU, same inputs → 0x000000F0. LHU addr=0x2, rdata=0x80010000 → 0x00008001.
- LH addr=0x3 → no dmem_req; out_valid at T+1 with misaligned=1. SW addr=0x6 → same.
- LW with gnt never asserted, TIMEOUT=16 → dmem_req high exactly 16 cycles; out_valid with bus_error=1; next op accepted normally.
- rst asserted in WAIT_R, followed by rvalid → outputs 0, no out_valid, in_ready=1 after rst deasserts. ADDI (read_write=0000) → out_valid at T+1 with no dmem_req.
